alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_pkg.sv | 48 ++++
 rtl/alu_op_sequencer_sel_encoder.sv | 31 +++
 rtl/alu_op_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and ALU select codes for the matrix ALU op sequencer.
// Helper functions give the operand count and legality of a command op.
package alu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_TRANSPOSE = 3'd0,
        OP_ADD       = 3'd1,
        OP_SUB       = 3'd2,
        OP_MUL       = 3'd3,
        OP_SCALE     = 3'd4,
        OP_DET       = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EXEC = 3'd2,
        WAIT = 3'd3,
        READ = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LOAD = 2'd1,
        PH_EXEC = 2'd2,
        PH_READ = 2'd3
    } phase_e;

    localparam logic [5:0] E_BASE  = 6'd0;
    localparam logic [5:0] F_BASE  = 6'd9;
    localparam logic [5:0] G_BASE  = 6'd18;
    localparam logic [5:0] DET_OUT = 6'd27;
    localparam logic [5:0] OP_BASE = 6'd28;
    localparam logic [5:0] C_LOAD  = 6'd40;

    function automatic logic [4:0] op_count(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL: op_count = 5'd18;
            OP_SCALE:               op_count = 5'd10;
            default:                op_count = 5'd9;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        op_legal = (op <= 3'd5);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_sel_encoder.sv
// Maps (op, phase, idx) onto the matrix ALU select code.
// In LOAD, idx is the operand ordinal; in READ, it is the result element index.
module alu_sel_encoder
    import alu_op_sequencer_pkg::*;
#(
    parameter logic [5:0] IDLE_SEL = 6'd63
) (
    input  logic [2:0] op,
    input  phase_e     phase,
    input  logic [4:0] idx,
    output logic [5:0] sel
);

    always_comb begin
        sel = IDLE_SEL;
        case (phase)
            PH_LOAD: begin
                if (idx < 5'd9)
                    sel = E_BASE + {1'b0, idx};
                else if (op == OP_SCALE)
                    sel = C_LOAD;
                else
                    sel = F_BASE + ({1'b0, idx} - 6'd9);
            end
            PH_EXEC: sel = OP_BASE + {3'b000, op};
            PH_READ: sel = (op == OP_DET) ? DET_OUT : G_BASE + {1'b0, idx};
            default: sel = IDLE_SEL;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences operand loads, the execute strobe and result readout for a 3x3 matrix ALU.
// alu_sel/alu_ele_in are registered; res_data is a straight pass-through of alu_ele_out.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter logic [5:0] IDLE_SEL = 6'd63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_last,
    output logic        busy,
    output logic        err,
    output logic [5:0]  alu_sel,
    output logic [31:0] alu_ele_in,
    input  logic [31:0] alu_ele_out
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [5:0]  sel_q, sel_d;
    logic [31:0] ele_q, ele_d;
    logic        err_q, err_d;

    logic [4:0]  need;
    phase_e      enc_phase;
    logic [4:0]  enc_idx;
    logic [5:0]  enc_sel;

    assign need = op_count(op_q);

    alu_sel_encoder #(.IDLE_SEL(IDLE_SEL)) u_enc (
        .op    (op_q),
        .phase (enc_phase),
        .idx   (enc_idx),
        .sel   (enc_sel)
    );

    // Encoder request: the select code the next cycle would drive from this state.
    always_comb begin
        enc_phase = PH_IDLE;
        enc_idx   = cnt_q;
        case (state_q)
            LOAD:    enc_phase = (cnt_q == need) ? PH_EXEC : PH_LOAD;
            WAIT:    begin enc_phase = PH_READ; enc_idx = 5'd0; end
            READ:    begin enc_phase = PH_READ; enc_idx = cnt_q + 5'd1; end
            default: enc_phase = PH_IDLE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sel_d   = IDLE_SEL;
        ele_d   = ele_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (op_legal(cmd_op)) begin
                        op_d    = cmd_op;
                        cnt_d   = 5'd0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // cnt_q == need is the cycle the final operand is being written.
                if (cnt_q == need) begin
                    sel_d   = enc_sel;
                    state_d = EXEC;
                end else if (in_valid) begin
                    sel_d = enc_sel;
                    ele_d = in_data;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            EXEC: state_d = WAIT;
            WAIT: begin
                sel_d   = enc_sel;
                cnt_d   = 5'd0;
                state_d = READ;
            end
            READ: begin
                sel_d = sel_q;
                if (res_ready) begin
                    if (res_last) begin
                        sel_d   = IDLE_SEL;
                        cnt_d   = 5'd0;
                        state_d = IDLE;
                    end else begin
                        sel_d = enc_sel;
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            sel_q   <= IDLE_SEL;
            ele_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            ele_q   <= ele_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign in_ready   = (state_q == LOAD) && (cnt_q != need);
    assign res_valid  = (state_q == READ);
    assign res_last   = (state_q == READ) && ((op_q == OP_DET) || (cnt_q == 5'd8));
    assign res_data   = alu_ele_out;
    assign alu_sel    = sel_q;
    assign alu_ele_in = ele_q;
    assign err        = err_q;

endmodule
